ms_arbiter: RTL and testbench

MS_ARBITER -- requirements
Module: ms_arbiter

---
 rtl/ms_arb_pkg.sv | 9 +
 rtl/ms_arbiter_if.sv | 29 ++
 rtl/ms_rr_pick.sv | 23 ++
 rtl/ms_arbiter.sv | 84 ++++++++
 tb/tb_ms_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ms_arb_pkg.sv
// Shared types and default sizing for the shared-slave round-robin arbiter.
package ms_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;
endpackage

// File: rtl/ms_arbiter_if.sv
// Requester-side and slave-side bus of the arbiter, grouped as one interface.
interface ms_arbiter_if
  import ms_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             gnt;
  logic                           err;
  logic                           s_valid;
  logic [ADDR_W-1:0]              s_addr;
  logic [DATA_W-1:0]              s_data;
  logic                           sready;

  // master: the arbiter itself; slave: requesters plus the shared target
  modport master (
    input  req, req_addr, req_data, sready,
    output ack, gnt, err, s_valid, s_addr, s_data
  );
  modport slave (
    output req, req_addr, req_data, sready,
    input  ack, gnt, err, s_valid, s_addr, s_data
  );
endinterface

// File: rtl/ms_rr_pick.sv
// Combinational round-robin pick: first set request at or after last+1 (mod NUM_REQ).
module ms_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);
  int j;

  // Scan farthest-first so the nearest requester after 'last' overwrites the rest.
  always_comb begin
    winner = '0;
    j      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % NUM_REQ;
      if (req[j]) winner = ($clog2(NUM_REQ))'(j);
    end
  end

  assign any = |req;
endmodule

// File: rtl/ms_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters one shared slave, with a
// per-transfer sready timeout that aborts the transfer and raises err.
module ms_arbiter
  import ms_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic         clk,
  input logic         rstn,
  ms_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] last, cur, win;
  logic [CNT_W-1:0] cnt;
  logic             any, load, hs, tmo;

  ms_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req),
    .last   (last),
    .winner (win),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake is checked before the timeout so a late sready still completes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    hs        = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (any) begin
        load      = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (bus.sready) begin
        hs        = 1'b1;
        state_nxt = IDLE;
      end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
        tmo       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ack = hs ? bus.gnt : '0;
  assign bus.err = tmo;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.s_valid <= 1'b0;
      bus.gnt     <= '0;
      bus.s_addr  <= '0;
      bus.s_data  <= '0;
      cnt         <= '0;
      cur         <= '0;
      last        <= IDX_W'(NUM_REQ - 1);
    end else if (load) begin
      bus.s_valid <= 1'b1;
      bus.gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
      bus.s_addr  <= bus.req_addr[win];
      bus.s_data  <= bus.req_data[win];
      cnt         <= '0;
      cur         <= win;
    end else if (hs || tmo) begin
      bus.s_valid <= 1'b0;
      bus.gnt     <= '0;
      last        <= cur;
    end else if (state == BUSY) begin
      cnt         <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ms_arbiter.sv
// Randomized bench for ms_arbiter: transfer-level reference model plus directed scenarios.
module tb_ms_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ms_arbiter_if #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(32)) bus ();

  ms_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Round-robin rule: first pending requester strictly after 'last', wrapping.
  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Transfer-level model: is a transfer open, whose, since which cycle, what payload.
  bit          m_busy;
  int          m_who, m_last, m_start, cyc, pick;
  logic [7:0]  m_addr;
  logic [31:0] m_data;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_who <= 0; m_last <= N - 1; m_start <= 0; cyc <= 0;
      m_addr <= '0;   m_data <= '0;
    end else begin
      cyc <= cyc + 1;
      if (!m_busy) begin
        pick = rr(bus.req, m_last);
        if (pick >= 0) begin
          m_busy <= 1'b1; m_who <= pick; m_start <= cyc + 1;
          m_addr <= bus.req_addr[pick]; m_data <= bus.req_data[pick];
        end
      end else if (bus.sready || (cyc - m_start) == T) begin
        m_busy <= 1'b0; m_last <= m_who;
      end
    end
  end

  logic [N-1:0] seen_ack = '0;
  int ack_idx[$];
  int ack_cyc[$];
  int err_cnt = 0;

  always @(negedge clk) begin
    logic [N-1:0] one, e_gnt, e_ack;
    logic         e_err;
    one   = 1;
    e_gnt = m_busy ? (one << m_who) : '0;
    e_ack = (m_busy && bus.sready) ? e_gnt : '0;
    e_err = m_busy && !bus.sready && (cyc - m_start) == T;
    if (chk_en) begin
      chk("s_valid", bus.s_valid, m_busy);
      chk("gnt", bus.gnt, e_gnt);
      chk("ack", bus.ack, e_ack);
      chk("err", bus.err, e_err);
      if (m_busy) begin
        chk("s_addr", bus.s_addr, m_addr);
        chk("s_data", bus.s_data, m_data);
      end
    end
    seen_ack = bus.ack;
    for (int i = 0; i < N; i++)
      if (bus.ack[i]) begin ack_idx.push_back(i); ack_cyc.push_back(cyc); end
    if (bus.err) err_cnt++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.req = '0; bus.sready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i] = 8'(8'h10 + i);
      bus.req_data[i] = 32'(32'h1000 + i);
    end
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    rstn = 1'b0;
    mid();
    chk("rst s_valid", bus.s_valid, 0);
    chk("rst gnt", bus.gnt, 0);
    chk("rst err", bus.err, 0);
    chk("rst ack", bus.ack, 0);
    chk("rst s_addr", bus.s_addr, 0);
    chk("rst s_data", bus.s_data, 0);
    step();
    rstn = 1'b1;
    ack_idx.delete(); ack_cyc.delete(); err_cnt = 0;
  endtask

  initial begin
    int hi, err_at, n;
    idle_inputs();
    step(); step();
    chk_en = 1'b1;

    // Full contention, always-ready slave: strict rotation, one ack per 2 cycles.
    do_reset();
    bus.req = 4'b1111; bus.sready = 1'b1;
    for (int c = 0; c < 12; c++) step();
    idle_inputs();
    n = ack_idx.size();
    chk("t_rot count>=5", n >= 5, 1);
    for (int i = 0; i < 5 && i < n; i++) begin
      chk($sformatf("t_rot idx%0d", i), ack_idx[i], i % N);
      if (i > 0) chk($sformatf("t_rot gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 2);
    end

    // Single requester, slave ready after three wait cycles.
    do_reset();
    bus.req = 4'b0100; bus.req_addr[2] = 8'h5A; bus.req_data[2] = 32'hDEAD_BEEF;
    mid();
    chk("t_wait idle gnt", bus.gnt, 0);
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) bus.sready = 1'b1;
      mid();
      hi += int'(bus.s_valid);
      chk($sformatf("t_wait ack k%0d", k), bus.ack, (k == 3) ? 4'b0100 : 4'b0000);
    end
    chk("t_wait s_addr", bus.s_addr, 8'h5A);
    chk("t_wait s_data", bus.s_data, 32'hDEAD_BEEF);
    step(); bus.req = '0; bus.sready = 1'b0;
    mid();
    chk("t_wait s_valid after", bus.s_valid, 0);
    chk("t_wait valid cycles", hi, 4);

    // Timeout: err exactly 16 cycles after grant, then next pending requester.
    do_reset();
    bus.req = 4'b0010;
    step(); bus.req = 4'b1010;
    mid();
    chk("t_tmo gnt", bus.gnt, 4'b0010);
    err_at = -1;
    for (int k = 1; k <= 20; k++) begin
      step(); mid();
      if (bus.err && err_at < 0) err_at = k;
      if (k == 17) chk("t_tmo idle gnt", bus.gnt, 0);
      if (k == 18) chk("t_tmo next gnt", bus.gnt, 4'b1000);
    end
    chk("t_tmo err cycle", err_at, 16);
    chk("t_tmo err count", err_cnt, 1);
    chk("t_tmo no ack", ack_idx.size(), 0);
    step(); bus.sready = 1'b1;
    mid();
    chk("t_tmo flush ack", bus.ack, 4'b1000);
    step(); idle_inputs();

    // sready lands on the timeout cycle: handshake wins.
    do_reset();
    bus.req = 4'b0001;
    step();
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 16) bus.sready = 1'b1;
      mid();
    end
    chk("t_edge ack", bus.ack, 4'b0001);
    chk("t_edge err", bus.err, 0);
    step(); idle_inputs();
    mid();
    chk("t_edge err total", err_cnt, 0);
    chk("t_edge s_valid", bus.s_valid, 0);

    // Reset mid-transfer drops it asynchronously; priority restarts at requester 0.
    do_reset();
    bus.req = 4'b0100;
    step(); step();
    mid();
    chk("t_arst gnt before", bus.gnt, 4'b0100);
    #2 rstn = 1'b0;
    #1;
    chk("t_arst s_valid", bus.s_valid, 0);
    chk("t_arst gnt", bus.gnt, 0);
    chk("t_arst ack", bus.ack, 0);
    step(); bus.req = 4'b0101;
    step(); rstn = 1'b1;
    step();
    mid();
    chk("t_arst first gnt", bus.gnt, 4'b0001);
    chk("t_arst acks", ack_idx.size(), 0);
    step(); idle_inputs(); bus.sready = 1'b1;
    step(); bus.sready = 1'b0;

    // Granted requester withdraws mid-transfer; latched payload still completes.
    do_reset();
    bus.req = 4'b1000; bus.req_addr[3] = 8'hC3; bus.req_data[3] = 32'h1234_5678;
    step();
    step(); bus.req = '0; bus.req_addr[3] = 8'h00; bus.req_data[3] = 32'h0;
    step(); bus.sready = 1'b1;
    mid();
    chk("t_drop ack", bus.ack, 4'b1000);
    chk("t_drop s_addr", bus.s_addr, 8'hC3);
    chk("t_drop s_data", bus.s_data, 32'h1234_5678);
    step(); bus.sready = 1'b0;
    mid();
    chk("t_drop s_valid", bus.s_valid, 0);

    // Random traffic: busy slave first, then a mostly-stalled slave for timeouts.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (seen_ack[i])                      bus.req[i] = 1'b0;
        else if (!bus.req[i])                 bus.req[i] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 31) == 0)  bus.req[i] = 1'b0;
        bus.req_addr[i] = 8'($urandom);
        bus.req_data[i] = $urandom;
      end
      bus.sready = (c < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 24) == 0);
    end
    step(); idle_inputs();
    step(); step(); step();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
